score_display_mux: RTL and testbench
====================================

// Module: score_display_mux
// PURPOSE
//   Downstream consumer of the two-digit BCD score counter. Samples the live score digits and
//   tracks a high score. Drives a 4-digit common-anode seven-segment display, time-multiplexed:
//   - right pair: current score; left pair: high score.
//   Sits between the score counter outputs and the board display pins.
// PARAMETERS
//   REFRESH_DIV  100_000     clk cycles each digit slot is lit (>=2)
//   BLINK_DIV    25_000_000  clk cycles per blink phase (HISCORE_BLINK_EN only, >=2)
// PORTS
//   clk       in   1  system clock, all state on rising edge
//   reset     in   1  asynchronous, active-low; 0 = reset
//   dig0      in   4  current score ones digit (BCD)
//   dig1      in   4  current score tens digit (BCD)
//   clr       in   1  score clear pulse (same strobe that clears the counter)
//   hs_clr    in   1  high-score clear, 1-cycle pulse
//   an        out  4  digit anodes, active-low, an[0] = rightmost
//   seg       out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp        out  1  decimal point, active-low
//   hi_dig0   out  4  high score ones digit
//   hi_dig1   out  4  high score tens digit
//   new_hi    out  1  1-cycle pulse when high score is raised
// BEHAVIOUR
// - Reset (reset=0, async):
//   - refresh count=0, slot=0, score_q=0, hi=0.
//   - Outputs: an=4'b1111, seg=7'h7F, dp=1, new_hi=0.
//   - Asserting reset mid-operation blanks the display immediately.
// - Input stage: {dig1,dig0} registered into score_q every cycle; 1-cycle latency.
// - Refresh counter: counts 0..REFRESH_DIV-1.
//   - At terminal count it wraps to 0 and slot advances 0->1->2->3->0.
// - Slot map (an value / source digit / blanking):
//   - slot0: 1110 / score_q ones / never blank.
//   - slot1: 1101 / score_q tens / blank if 0.
//   - slot2: 1011 / hi ones / never blank.
//   - slot3: 0111 / hi tens / blank if 0.
// - A blanked slot drives seg=7'h7F with its anode still active.
// - dp=0 only in slot2 (separator after the high-score pair); dp=1 otherwise.
// - Output stage: an, seg and dp are registered.
//   - They reflect the slot and source values from the previous cycle (1-cycle latency).
// - Decoder: BCD 0-9 to standard patterns, e.g. 0=7'h40, 1=7'h79, 8=7'h00.
//   - Codes 10-15 decode to 7'h7F (blank); never an X.
// - High score compare: unsigned 8-bit compare of {tens,ones} (BCD order is lexicographic).
//   - If score_q > hi: hi<=score_q and new_hi=1, both on the next edge.
//   - The pulse repeats for every further increment while the score leads.
// - hs_clr has priority over update: hi<=0 and new_hi stays 0 that cycle.
// - Score wrap 99->00 or clr never lowers hi.
// - Simultaneous hs_clr and a higher score: hi=0 that cycle; the score re-wins the next cycle.
// CONFIGURATION
// - HISCORE_BLINK_EN defined:
//   - Adds blink_active flag and blink phase counter (BLINK_DIV).
//   - new_hi sets blink_active; clr or hs_clr clears it (clear wins over set).
//   - While blink_active and phase=1: slots 2,3 drive an=4'b1111.
//   - The refresh sequence is unchanged.
//   - Phase counter resets to 0 whenever blink_active rises.
// - HISCORE_BLINK_EN undefined:
//   - No blink logic; clr is ignored; slots 2,3 always lit.
// TESTING (REFRESH_DIV=4, BLINK_DIV=8)
// - Reset low -> an=1111, seg=7F, hi=00; release with score 00 -> slot0 an=1110 seg=40,
//   slot1 blanked, slot advance every 4 cycles.
// - Score 07 -> 12 -> hi follows to 12 with one new_hi pulse per raise.
//   Slot3 shows 1 (seg=79); dp=0 only in slot2.
// - Score 99 then clr->00 -> hi stays 99, new_hi=0, slot1 blanked, slot3 shows 9.
// - hs_clr with score 45 asserted same cycle as 46 arrives -> hi=00 that cycle, then hi=46
//   with new_hi pulse.
// - Drive dig0=4'hC -> slot0 seg=7F; assert reset in slot2 -> an=1111 same time step (async).
// - HISCORE_BLINK_EN: raise hi -> slots 2,3 dark every other 8-cycle phase;
//   clr -> blinking stops, slots 2,3 lit.

Source files
------------

// File: rtl/score_display_mux.sv
// Four-digit multiplexed seven-segment driver: live score on the right pair, high score on the left.
// Optional macro HISCORE_BLINK_EN blinks the high-score pair after each new high score.
module score_display_mux #(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic       clr,
    input  logic       hs_clr,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] hi_dig0,
    output logic [3:0] hi_dig1,
    output logic       new_hi
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [7:0]    score_q_reg;
    logic [7:0]    hi_reg;
    logic          new_hi_reg;
    logic [RW-1:0] refresh_cnt_reg;
    logic [1:0]    slot_reg;
    logic [3:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;
    logic          dark_hi;

    // Score capture and high-score tracking; BCD digits compare correctly as a plain byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_q_reg <= 8'h00;
            hi_reg      <= 8'h00;
            new_hi_reg  <= 1'b0;
        end else begin
            score_q_reg <= {dig1, dig0};
            if (hs_clr) begin
                hi_reg     <= 8'h00;
                new_hi_reg <= 1'b0;
            end else if (score_q_reg > hi_reg) begin
                hi_reg     <= score_q_reg;
                new_hi_reg <= 1'b1;
            end else begin
                new_hi_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt_reg <= '0;
            slot_reg        <= 2'd0;
        end else if (refresh_cnt_reg == REFRESH_LAST) begin
            refresh_cnt_reg <= '0;
            slot_reg        <= slot_reg + 2'd1;
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
        end
    end

`ifdef HISCORE_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic          blink_active_reg;
    logic          blink_phase_reg;
    logic [BW-1:0] blink_cnt_reg;

    // A clear on the same edge as a new high score leaves blinking off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_active_reg <= 1'b0;
            blink_phase_reg  <= 1'b0;
            blink_cnt_reg    <= '0;
        end else if (clr || hs_clr) begin
            blink_active_reg <= 1'b0;
            blink_phase_reg  <= 1'b0;
            blink_cnt_reg    <= '0;
        end else if (new_hi_reg && !blink_active_reg) begin
            blink_active_reg <= 1'b1;
            blink_phase_reg  <= 1'b0;
            blink_cnt_reg    <= '0;
        end else if (blink_active_reg) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    assign dark_hi = blink_active_reg & blink_phase_reg;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign dark_hi    = 1'b0;
`endif

    always_comb begin
        logic [3:0] digit;
        logic       blank;
        an_next = 4'b1111;
        dp_next = 1'b1;
        digit   = 4'd0;
        blank   = 1'b0;
        case (slot_reg)
            2'd0: begin
                an_next = 4'b1110;
                digit   = score_q_reg[3:0];
            end
            2'd1: begin
                an_next = 4'b1101;
                digit   = score_q_reg[7:4];
                blank   = (score_q_reg[7:4] == 4'd0);
            end
            2'd2: begin
                an_next = 4'b1011;
                digit   = hi_reg[3:0];
                dp_next = 1'b0;
            end
            default: begin
                an_next = 4'b0111;
                digit   = hi_reg[7:4];
                blank   = (hi_reg[7:4] == 4'd0);
            end
        endcase
        if (dark_hi && slot_reg[1]) begin
            an_next = 4'b1111;
        end
        seg_next = blank ? 7'h7F : bcd_to_seg(digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_reg  <= 4'b1111;
            seg_reg <= 7'h7F;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign an      = an_reg;
    assign seg     = seg_reg;
    assign dp      = dp_reg;
    assign hi_dig0 = hi_reg[3:0];
    assign hi_dig1 = hi_reg[7:4];
    assign new_hi  = new_hi_reg;

endmodule

// File: tb/tb_score_display_mux.sv
// Directed bench for score_display_mux with REFRESH_DIV=4, BLINK_DIV=8.
module tb_score_display_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dig0, dig1;
    logic       clr, hs_clr;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] hi_dig0, hi_dig1;
    logic       new_hi;

    int checks   = 0;
    int failures = 0;

    score_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .reset(reset), .dig0(dig0), .dig1(dig1), .clr(clr), .hs_clr(hs_clr),
        .an(an), .seg(seg), .dp(dp), .hi_dig0(hi_dig0), .hi_dig1(hi_dig1), .new_hi(new_hi)
    );

    always #5 clk = ~clk;

    // Expected slot shown on the display: refresh position of the previous cycle.
    logic [1:0] m_cnt, m_slot, o_slot;
    logic       o_valid;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= 2'd0; m_slot <= 2'd0; o_slot <= 2'd0; o_valid <= 1'b0;
        end else begin
            o_slot  <= m_slot;
            o_valid <= 1'b1;
            if (m_cnt == 2'd3) begin
                m_cnt  <= 2'd0;
                m_slot <= m_slot + 2'd1;
            end else begin
                m_cnt <= m_cnt + 2'd1;
            end
        end
    end

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d0;
        logic [1:0] slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [7:0] hi;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic wait_out_slot(input logic [1:0] s);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_valid && o_slot == s) begin
                found = 1;
                break;
            end
        end
        if (!found) check("slot_timeout", 8'h00, 8'h01);
    endtask

    task automatic count_pulses(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (new_hi) c++;
        end
    endtask

    task automatic hi_dark(input int n, output int dark, output int lit, output int bad);
        dark = 0; lit = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_valid && o_slot[1]) begin
                if (an == 4'b1111) dark++; else lit++;
            end else if (o_valid && an == 4'b1111) begin
                bad++;
            end
        end
    endtask

    initial begin
        int c, dark, lit, bad;
        vecs[0]  = '{4'd0, 4'd0, 2'd0, 4'b1110, 7'h40, 1'b1, 8'h00};
        vecs[1]  = '{4'd0, 4'd0, 2'd1, 4'b1101, 7'h7F, 1'b1, 8'h00};
        vecs[2]  = '{4'd0, 4'd0, 2'd2, 4'b1011, 7'h40, 1'b0, 8'h00};
        vecs[3]  = '{4'd0, 4'd0, 2'd3, 4'b0111, 7'h7F, 1'b1, 8'h00};
        vecs[4]  = '{4'd0, 4'd7, 2'd0, 4'b1110, 7'h78, 1'b1, 8'h07};
        vecs[5]  = '{4'd1, 4'd2, 2'd1, 4'b1101, 7'h79, 1'b1, 8'h12};
        vecs[6]  = '{4'd1, 4'd2, 2'd2, 4'b1011, 7'h24, 1'b0, 8'h12};
        vecs[7]  = '{4'd1, 4'd2, 2'd3, 4'b0111, 7'h79, 1'b1, 8'h12};
        vecs[8]  = '{4'd9, 4'd9, 2'd3, 4'b0111, 7'h10, 1'b1, 8'h99};
        vecs[9]  = '{4'd0, 4'd0, 2'd1, 4'b1101, 7'h7F, 1'b1, 8'h99};
        vecs[10] = '{4'd0, 4'd0, 2'd3, 4'b0111, 7'h10, 1'b1, 8'h99};
        vecs[11] = '{4'd0, 4'd0, 2'd2, 4'b1011, 7'h10, 1'b0, 8'h99};
        vecs[12] = '{4'd0, 4'hC, 2'd0, 4'b1110, 7'h7F, 1'b1, 8'h99};
        vecs[13] = '{4'd3, 4'hC, 2'd1, 4'b1101, 7'h30, 1'b1, 8'h99};

        reset = 1'b0; dig0 = 4'd0; dig1 = 4'd0; clr = 1'b0; hs_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", 8'(an), 8'h0F);
        check("rst_seg", 8'(seg), 8'h7F);
        check("rst_dp", 8'(dp), 8'h01);
        check("rst_hi", {hi_dig1, hi_dig0}, 8'h00);
        check("rst_new_hi", 8'(new_hi), 8'h00);

        // Release: four cycles of slot0, then slot1 blanked.
        reset = 1'b1;
        @(negedge clk);
        check("rel_an_c1", 8'(an), 8'h0E);
        check("rel_seg_c1", 8'(seg), 8'h40);
        repeat (3) @(negedge clk);
        check("rel_an_c4", 8'(an), 8'h0E);
        @(negedge clk);
        check("rel_an_c5", 8'(an), 8'h0D);
        check("rel_seg_c5", 8'(seg), 8'h7F);

        // First raise: new_hi exactly two edges after the input changes.
        dig1 = 4'd0; dig0 = 4'd7;
        @(negedge clk);
        check("raise_nh_lat1", 8'(new_hi), 8'h00);
        @(negedge clk);
        check("raise_nh_lat2", 8'(new_hi), 8'h01);
        check("raise_hi_07", {hi_dig1, hi_dig0}, 8'h07);
        @(negedge clk);
        check("raise_nh_drop", 8'(new_hi), 8'h00);

        // Consecutive increments each pulse.
        dig0 = 4'd8;
        @(negedge clk);
        dig0 = 4'd9;
        count_pulses(5, c);
        check("inc_pulses", 8'(c), 8'h02);
        check("inc_hi_09", {hi_dig1, hi_dig0}, 8'h09);
        dig1 = 4'd1; dig0 = 4'd2;
        count_pulses(5, c);
        check("raise12_pulses", 8'(c), 8'h01);
        check("raise12_hi", {hi_dig1, hi_dig0}, 8'h12);
        dig1 = 4'd4; dig0 = 4'd5;
        count_pulses(5, c);
        check("raise45_hi", {hi_dig1, hi_dig0}, 8'h45);

        // hs_clr together with a higher score: clear wins, then the score re-wins.
        dig0 = 4'd6; hs_clr = 1'b1;
        @(negedge clk);
        hs_clr = 1'b0;
        check("hsclr_hi_00", {hi_dig1, hi_dig0}, 8'h00);
        check("hsclr_nh_0", 8'(new_hi), 8'h00);
        @(negedge clk);
        check("hsclr_hi_46", {hi_dig1, hi_dig0}, 8'h46);
        check("hsclr_nh_1", 8'(new_hi), 8'h01);

        dig1 = 4'd0; dig0 = 4'd0;
        repeat (2) @(negedge clk);
        hs_clr = 1'b1;
        @(negedge clk);
        hs_clr = 1'b0;
        @(negedge clk);
        check("zero_hi", {hi_dig1, hi_dig0}, 8'h00);
        check("zero_nh", 8'(new_hi), 8'h00);

        // Table: apply score, let it settle, pulse clr, then inspect the chosen slot.
        for (int i = 0; i < 14; i++) begin
            dig1 = vecs[i].d1; dig0 = vecs[i].d0;
            repeat (3) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            wait_out_slot(vecs[i].slot);
            check($sformatf("v%0d_an", i), 8'(an), 8'(vecs[i].an));
            check($sformatf("v%0d_seg", i), 8'(seg), 8'(vecs[i].seg));
            check($sformatf("v%0d_dp", i), 8'(dp), 8'(vecs[i].dp));
            check($sformatf("v%0d_hi", i), {hi_dig1, hi_dig0}, vecs[i].hi);
            check($sformatf("v%0d_nh", i), 8'(new_hi), 8'h00);
        end

        // Asynchronous reset while slot2 is lit blanks the display without a clock edge.
        wait_out_slot(2'd2);
        #2 reset = 1'b0;
        #1;
        check("async_an", 8'(an), 8'h0F);
        check("async_seg", 8'(seg), 8'h7F);
        check("async_dp", 8'(dp), 8'h01);
        check("async_hi", {hi_dig1, hi_dig0}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        dig1 = 4'd0; dig0 = 4'd5;

        hi_dark(64, dark, lit, bad);
`ifdef HISCORE_BLINK_EN
        check("blink_dark_seen", 8'(dark > 0), 8'h01);
`else
        check("noblink_dark", 8'(dark), 8'h00);
`endif
        check("blink_lit_seen", 8'(lit > 0), 8'h01);
        check("blink_low_pair", 8'(bad), 8'h00);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        hi_dark(32, dark, lit, bad);
        check("after_clr_dark", 8'(dark), 8'h00);
        check("after_clr_hi", {hi_dig1, hi_dig0}, 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
